// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the master-slave SR flip-flop driver.
package sr_drv_pkg;

    // Driver sequencing states.
    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SHIFT,
        FLUSH
    } state_e;

    // Excitation codes, ordered {S, R}. S=R=1 is deliberately absent.
    localparam logic [1:0] EXC_HOLD = 2'b00;
    localparam logic [1:0] EXC_SET  = 2'b10;
    localparam logic [1:0] EXC_RST  = 2'b01;

    // Cycles spent forcing the flop clear after reset release.
    localparam int INIT_CYCLES = 2;

endpackage : sr_drv_pkg

// File: rtl/sr_excite.sv
// Combinational SR excitation encoder: maps (current state, target) to {S, R}.
// Depends only on the internally tracked state, never on the flop's Q.
module sr_excite
    import sr_drv_pkg::*;
(
    input  logic       cur_i,
    input  logic       target_i,
    output logic [1:0] sr_o
);

    // Pick the excitation that moves the flop from cur_i to target_i.
    always_comb begin
        // NOTE: default assigned first so every path drives sr_o and no latch is inferred.
        sr_o = EXC_HOLD;
        if (target_i && !cur_i) begin
            sr_o = EXC_SET;
        end else if (!target_i && cur_i) begin
            sr_o = EXC_RST;
        end
    end

endmodule : sr_excite

// File: rtl/sr_ff_driver.sv
// Serialises parallel words LSB-first into S/R excitation for an external
// master-slave SR flip-flop, reads Q/Qbar back two cycles later and reports
// per-word readback, mismatch flags and a saturating error count.
module sr_ff_driver
    import sr_drv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             S,
    output logic             R,
    input  logic             Q,
    input  logic             Qbar,
    output logic             done,
    output logic [WIDTH-1:0] rb_data,
    output logic             word_err,
    output logic             err_sticky,
    output logic [ERRW-1:0]  err_count
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam int              IW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH);
    localparam logic [1:0]      INIT_LAST = 2'(INIT_CYCLES);

    // Sequencer state and registered outputs.
    state_e           state_q;
    logic [1:0]       init_cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             cur_q;
    logic             s_q, r_q;
    logic             in_ready_q;
    logic             done_q;

    // Readback pipeline and error bookkeeping.
    logic             exp1_q, exp2_q;
    logic             v1_q, v2_q;
    logic [IW-1:0]    chk_idx_q;
    logic [WIDTH-1:0] rb_q;
    logic             word_err_q;
    logic             sticky_q;
    logic [ERRW-1:0]  err_cnt_q;

    logic             accept;
    logic             drive_bit;
    logic             target;
    logic             mismatch;
    logic [1:0]       exc;

    assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
    assign drive_bit = accept || ((state_q == SHIFT) && (bit_cnt_q != LAST_BIT));
    // Bit 0 comes straight from the input word on the accepting edge.
    assign target    = (state_q == IDLE) ? in_data[0] : sh_q[0];
    // Q must match the delayed target and Qbar must be its complement.
    assign mismatch  = (Q != exp2_q) || (Qbar == Q);

    sr_excite u_excite (
        .cur_i    (cur_q),
        .target_i (target),
        .sr_o     (exc)
    );

    // Sequencer: INIT clear, IDLE handshake, SHIFT bits out, FLUSH last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            cur_q      <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            done_q <= 1'b0;
            unique case (state_q)
                INIT: begin
                    cur_q <= 1'b0;
                    if (init_cnt_q == INIT_LAST) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        {s_q, r_q} <= EXC_HOLD;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                        {s_q, r_q} <= EXC_RST;
                    end
                end
                IDLE: begin
                    {s_q, r_q} <= EXC_HOLD;
                    if (accept) begin
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        sh_q       <= in_data >> 1;
                        bit_cnt_q  <= CW'(1);
                        {s_q, r_q} <= exc;
                        cur_q      <= target;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q    <= FLUSH;
                        {s_q, r_q} <= EXC_HOLD;
                    end else begin
                        {s_q, r_q} <= exc;
                        cur_q      <= target;
                        sh_q       <= sh_q >> 1;
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                    end
                end
                FLUSH: begin
                    state_q    <= IDLE;
                    {s_q, r_q} <= EXC_HOLD;
                    in_ready_q <= 1'b1;
                    done_q     <= 1'b1;
                end
                default: begin
                    state_q    <= INIT;
                    {s_q, r_q} <= EXC_HOLD;
                end
            endcase
        end
    end

    // Delay each driven target two cycles, then compare it with the flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp1_q     <= 1'b0;
            exp2_q     <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            chk_idx_q  <= '0;
            rb_q       <= '0;
            word_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            v1_q   <= drive_bit;
            exp1_q <= target;
            v2_q   <= v1_q;
            exp2_q <= exp1_q;
            if (accept) begin
                rb_q       <= '0;
                word_err_q <= 1'b0;
                chk_idx_q  <= '0;
            end else if (v2_q) begin
                rb_q[chk_idx_q] <= Q;
                chk_idx_q       <= chk_idx_q + 1'b1;
                if (mismatch) begin
                    word_err_q <= 1'b1;
                end
            end
            if (v2_q && mismatch) begin
                sticky_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign S          = s_q;
    assign R          = r_q;
    assign done       = done_q;
    assign rb_data    = rb_q;
    assign word_err   = word_err_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_cnt_q;

endmodule : sr_ff_driver

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver driving a behavioural master-slave SR flop.
// A second instance with a 2-bit error counter shares the stimulus.
module tb_sr_ff_driver;

    localparam logic [1:0] H  = 2'b00;
    localparam logic [1:0] ST = 2'b10;
    localparam logic [1:0] RS = 2'b01;

    // Expected {S,R} per bit, bit i at [2*i +: 2], starting from cur = 0.
    localparam logic [15:0] SEQ_A5 = {ST, RS, ST, H, RS, ST, RS, ST};
    localparam logic [15:0] SEQ_00 = {H, H, H, H, H, H, H, H};
    localparam logic [15:0] SEQ_FF = {H, H, H, H, H, H, H, ST};
    localparam logic [15:0] SEQ_0F = {H, H, H, RS, H, H, H, ST};
    localparam logic [15:0] SEQ_01 = {H, H, H, H, H, H, RS, ST};
    localparam logic [15:0] SEQ_C3 = {H, ST, H, H, H, RS, H, ST};

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, S, R, Q, Qbar, done, word_err, err_sticky;
    logic [7:0] rb_data, err_count;

    logic       in_ready2, S2, R2, Q2, Qbar2, done2, word_err2, err_sticky2;
    logic [7:0] rb_data2;
    logic [1:0] err_count2;

    logic       f_stuck0  = 1'b0;
    logic       f_qbar_eq = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sr_ff_driver #(.WIDTH(8), .ERRW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .S(S), .R(R), .Q(Q), .Qbar(Qbar), .done(done),
        .rb_data(rb_data), .word_err(word_err), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    sr_ff_driver #(.WIDTH(8), .ERRW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .S(S2), .R(R2), .Q(Q2), .Qbar(Qbar2), .done(done2),
        .rb_data(rb_data2), .word_err(word_err2), .err_sticky(err_sticky2),
        .err_count(err_count2)
    );

    // Master-slave SR flop loads: master transparent while clk is low,
    // slave takes the master value on the rising edge. Start at 1 so INIT
    // has something to clear.
    logic m1 = 1'b1, q1 = 1'b1;
    logic m2 = 1'b1, q2 = 1'b1;

    always @(clk or S or R) begin
        if (!clk) begin
            if (S) m1 = 1'b1;
            else if (R) m1 = 1'b0;
        end
    end
    always @(clk or S2 or R2) begin
        if (!clk) begin
            if (S2) m2 = 1'b1;
            else if (R2) m2 = 1'b0;
        end
    end
    always @(posedge clk) begin
        q1 <= m1;
        q2 <= m2;
    end

    assign Q     = f_stuck0 ? 1'b0 : q1;
    assign Qbar  = f_qbar_eq ? Q : ~q1;
    assign Q2    = f_stuck0 ? 1'b0 : q2;
    assign Qbar2 = f_qbar_eq ? Q2 : ~q2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // S and R must never be high together on either instance.
    always @(negedge clk) begin
        check("s_and_r", {30'd0, S & R, S2 & R2}, 32'd0);
    end

    // Assert reset, check reset values, release and check the INIT sequence.
    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_sr_now", {S, R}, 2'b00);
        check("rst_done_now", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_sr", {S, R}, 2'b00);
        check("rst_done", done, 1'b0);
        check("rst_rb", rb_data, 8'h00);
        check("rst_werr", word_err, 1'b0);
        check("rst_sticky", err_sticky, 1'b0);
        check("rst_count", err_count, 8'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("init_sr", {S, R}, 2'b01);
            check("init_ready", in_ready, 1'b0);
            check("init_done", done, 1'b0);
        end
        @(negedge clk);
        check("idle_sr", {S, R}, 2'b00);
        check("idle_ready", in_ready, 1'b1);
        check("init_q_clear", Q, 1'b0);
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) check("ready_timeout", 1'b0, 1'b1);
    endtask

    // Called at the negedge of cycle 1 (just after the accepting edge).
    task automatic check_body(input string tag, input logic [15:0] seq,
                              input logic [7:0] exp_rb, input logic exp_err);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_sr"}, {S, R}, seq[2*i +: 2]);
            check({tag, "_busy"}, in_ready, 1'b0);
            @(negedge clk);
        end
        check({tag, "_flush_sr"}, {S, R}, 2'b00);
        check({tag, "_flush_done"}, done, 1'b0);
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_ready"}, in_ready, 1'b1);
        check({tag, "_rb"}, rb_data, exp_rb);
        check({tag, "_werr"}, word_err, exp_err);
    endtask

    task automatic drive_word(input string tag, input logic [7:0] data, input logic [15:0] seq,
                              input logic [7:0] exp_rb, input logic exp_err);
        wait_ready();
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_body(tag, seq, exp_rb, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Basic word after reset.
        apply_reset();
        drive_word("a5", 8'hA5, SEQ_A5, 8'hA5, 1'b0);
        check("a5_sticky", err_sticky, 1'b0);
        check("a5_count", err_count, 8'd0);

        // Back-to-back words with in_valid held high.
        apply_reset();
        wait_ready();
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'hFF;
        check_body("w00", SEQ_00, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_done_clear", done, 1'b0);
        check_body("wff", SEQ_FF, 8'hFF, 1'b0);

        // Q stuck at 0.
        apply_reset();
        f_stuck0 = 1'b1;
        drive_word("stuck", 8'h0F, SEQ_0F, 8'h00, 1'b1);
        check("stuck_count", err_count, 8'd4);
        check("stuck_sticky", err_sticky, 1'b1);
        check("stuck_count_sat", err_count2, 2'd3);
        f_stuck0 = 1'b0;
        @(negedge clk);
        check("stuck_werr_hold", word_err, 1'b1);
        check("stuck_rb_hold", rb_data, 8'h00);

        // Qbar tied to Q: every bit fails the complement check.
        apply_reset();
        f_qbar_eq = 1'b1;
        drive_word("qbar", 8'h01, SEQ_01, 8'h01, 1'b1);
        check("qbar_count", err_count, 8'd8);
        check("qbar_sticky", err_sticky, 1'b1);
        check("qbar_count_sat", err_count2, 2'd3);
        f_qbar_eq = 1'b0;

        // Reset while bit 3 of 8'hC3 is being driven.
        apply_reset();
        wait_ready();
        in_data  = 8'hC3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("c3_part_sr", {S, R}, SEQ_C3[2*i +: 2]);
            if (i < 3) @(negedge clk);
        end
        apply_reset();
        check("c3_rst_count", err_count, 8'd0);
        drive_word("c3", 8'hC3, SEQ_C3, 8'hC3, 1'b0);
        check("c3_count", err_count, 8'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sr_ff_driver
